// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load and a registered carry/borrow pulse.
// Latency: q updates on the edge that samples en/load; co and load_err follow the same edge.
// No backpressure: every enabled edge counts and there is no stall or hold-off path.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   mr       - synchronous active-high reset; has priority over load and en
//   en       - count enable
//   up       - direction: 1 = count up, 0 = count down
//   load     - parallel load strobe; has priority over en
//   din      - BCD load value, digit k at din[4k+3:4k]
//   q        - BCD count, digit k at q[4k+3:4k]
//   co       - one-cycle pulse after a wrap edge (or a limit hit when saturating)
//   load_err - one-cycle pulse after a load that contained a digit above 9
//
// Build option: define BCD_SATURATE_EN to make the counter stop at 0 and at all-9s
// instead of wrapping. co then pulses on every enabled edge attempted at the limit.

module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  mr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   q,
  output logic                  co,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                co_q, co_d;
  logic                err_q, err_d;

  // Ripple carry/borrow through the digits. After the loop, carry still set
  // means every digit rolled over, i.e. the whole counter reached a limit.
  logic                carry;
  logic [3:0]          dig;

  always_comb begin
    count_d = count_q;
    co_d    = 1'b0;
    err_d   = 1'b0;
    carry   = 1'b0;
    dig     = 4'd0;

    if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = din[4*k +: 4];
        if (dig > 4'd9) begin
          // Illegal digits are squashed so q can never hold a non-BCD value.
          count_d[4*k +: 4] = 4'd0;
          err_d             = 1'b1;
        end else begin
          count_d[4*k +: 4] = dig;
        end
      end
    end else if (en) begin
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (carry) begin
          if (up) begin
            if (dig == 4'd9) begin
              count_d[4*k +: 4] = 4'd0;
            end else begin
              count_d[4*k +: 4] = dig + 4'd1;
              carry             = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              count_d[4*k +: 4] = 4'd9;
            end else begin
              count_d[4*k +: 4] = dig - 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
`ifdef BCD_SATURATE_EN
      // At a limit the rolled-over value is discarded and the count holds.
      if (carry) begin
        count_d = count_q;
      end
`endif
      co_d = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      count_q <= '0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      co_q    <= co_d;
      err_q   <= err_d;
    end
  end

  assign q        = count_q;
  assign co       = co_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIGITS=2: vector table plus a full up-count walk.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Expected values are hand-written constants or decimal-to-BCD conversions of a loop index.

module tb_bcd_updown_counter;

  localparam int DIGITS = 2;

  logic       clk = 1'b0;
  logic       mr, en, up, load;
  logic [7:0] din;
  logic [7:0] q;
  logic       co, load_err;

  int checks = 0;
  int fails  = 0;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .mr       (mr),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .co       (co),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mr;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] din;
    logic [7:0] exp_q;
    logic       exp_co;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, input logic l, input logic e, input logic u,
                     input logic [7:0] d, input logic [7:0] eq, input logic ec,
                     input logic ee);
    vec_t v;
    v.mr = m; v.load = l; v.en = e; v.up = u; v.din = d;
    v.exp_q = eq; v.exp_co = ec; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic step(input logic m, input logic l, input logic e, input logic u,
                      input logic [7:0] d);
    mr = m; load = l; en = e; up = u; din = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q;
  logic       exp_co;

  initial begin
    mr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; din = 8'h00;

    //  mr load en up din    q     co err
    add(1, 0, 0, 1, 8'h00, 8'h00, 0, 0);  // plain reset
    add(0, 1, 1, 1, 8'h37, 8'h37, 0, 0);  // load before reset test
    add(1, 0, 1, 1, 8'h00, 8'h00, 0, 0);  // mr over en
    add(1, 1, 1, 0, 8'h55, 8'h00, 0, 0);  // mr over load
    add(0, 1, 1, 1, 8'h47, 8'h47, 0, 0);  // load wins over en
    add(0, 1, 0, 1, 8'h4C, 8'h40, 0, 1);  // bad low digit
    add(0, 0, 0, 1, 8'h00, 8'h40, 0, 0);  // hold, err pulse gone
    add(0, 1, 0, 1, 8'hF9, 8'h09, 0, 1);  // bad high digit
    add(0, 0, 1, 1, 8'h00, 8'h10, 0, 0);  // 09 -> 10
    add(0, 0, 1, 0, 8'h00, 8'h09, 0, 0);  // 10 -> 09, no borrow
    add(0, 1, 0, 0, 8'h50, 8'h50, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h51, 0, 0);  // direction toggles each edge
    add(0, 0, 1, 0, 8'h00, 8'h50, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h51, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h51, 0, 0);  // en low holds
    add(0, 0, 0, 1, 8'h00, 8'h51, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h51, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
`ifdef BCD_SATURATE_EN
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 0);  // down at 0 holds
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 0, 1, 8'h99, 8'h99, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h99, 1, 0);  // up at 99 holds, three edges
    add(0, 0, 1, 1, 8'h00, 8'h99, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h99, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h98, 0, 0);
`else
    add(0, 0, 1, 0, 8'h00, 8'h99, 1, 0);  // 00 -> 99 borrow
    add(0, 0, 1, 0, 8'h00, 8'h98, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h99, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 1, 0);  // 99 -> 00 carry
    add(0, 0, 0, 1, 8'h00, 8'h00, 0, 0);  // co is one cycle only
`endif
    add(0, 1, 0, 1, 8'h60, 8'h60, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h59, 0, 0);  // 60 -> 59

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].mr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din);
      chk("vec_q",        i, q,               vecs[i].exp_q);
      chk("vec_co",       i, {7'd0, co},       {7'd0, vecs[i].exp_co});
      chk("vec_load_err", i, {7'd0, load_err}, {7'd0, vecs[i].exp_err});
    end

    // Full up walk from reset: 100 enabled edges cover 09->10, 59->60 and 99->00.
    step(1, 0, 0, 1, 8'h00);
    chk("walk_reset", 0, q, 8'h00);
    for (int i = 1; i <= 100; i++) begin
      step(0, 0, 1, 1, 8'h00);
`ifdef BCD_SATURATE_EN
      if (i == 100) exp_q = 8'h99;
      else          exp_q = {4'((i % 100) / 10), 4'(i % 10)};
`else
      exp_q = {4'((i % 100) / 10), 4'(i % 10)};
`endif
      exp_co = (i == 100);
      chk("walk_q",  i, q,          exp_q);
      chk("walk_co", i, {7'd0, co}, {7'd0, exp_co});
    end

    // Held reset keeps the count at zero across several edges with load and en active.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 8'h88);
      chk("mr_hold_q",   i, q,          8'h00);
      chk("mr_hold_err", i, {7'd0, load_err}, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
